// File: rtl/window_pkg.sv
// Shared types and constants for the 3x3 window sequencer.
// Geometry widths here describe the default 5x5 build; instances derive their own widths.
package window_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    localparam int unsigned DEF_COLS = 5;
    localparam int unsigned DEF_ROWS = 5;

    localparam int unsigned COL_W = $clog2(DEF_COLS);
    localparam int unsigned ROW_W = $clog2(DEF_ROWS);

    localparam int unsigned EDGE_TOP   = 3;
    localparam int unsigned EDGE_BOT   = 2;
    localparam int unsigned EDGE_LEFT  = 1;
    localparam int unsigned EDGE_RIGHT = 0;

    // A modulus of 1 still needs one bit of storage.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mod_counter.sv
// Modulo-MOD up counter with synchronous clear; wrap flags the beat that returns it to zero.
module mod_counter
    import window_pkg::*;
#(
    parameter int unsigned MOD = 4,
    parameter int unsigned W   = cnt_width(MOD)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] count,
    output logic         wrap
);

    localparam logic [W-1:0] LAST = W'(MOD - 1);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    assign wrap  = en && (count_q == LAST);
    assign count = count_q;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en) begin
            count_d = wrap ? '0 : count_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/window_3x3_ctrl.sv
// Sequencer for the 3x3 window buffer: gates shifting, tags complete windows with
// centre coordinate and border flags, and reports end of frame and overrun.
module window_3x3_ctrl
    import window_pkg::*;
#(
    parameter int unsigned COLS = DEF_COLS,
    parameter int unsigned ROWS = DEF_ROWS
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start_i,
    input  logic                    valid_i,
    output logic                    shift_en_o,
    output logic                    win_valid_o,
    output logic [$clog2(COLS)-1:0] win_col_o,
    output logic [$clog2(ROWS)-1:0] win_row_o,
    output logic [3:0]              edge_o,
    output logic                    busy_o,
    output logic                    frame_done_o,
    output logic                    overrun_o
);

    localparam int unsigned CW = $clog2(COLS);
    localparam int unsigned RW = $clog2(ROWS);
    localparam int unsigned BW = cnt_width(ROWS - 2);

    localparam logic [CW-1:0] COL_FIRST_WIN = CW'(2);
    localparam logic [CW-1:0] COL_LAST      = CW'(COLS - 1);
    localparam logic [BW-1:0] BAND_LAST     = BW'(ROWS - 3);

    state_t state_q, state_d;

    logic          overrun_q, overrun_d;
    logic          win_valid_q;
    logic [CW-1:0] win_col_q;
    logic [RW-1:0] win_row_q;
    logic [3:0]    edge_q, edge_d;

    logic          accept;
    logic          win_hit;
    logic          last_beat;
    logic          cnt_clr;
    logic [CW-1:0] col_cnt;
    logic [BW-1:0] band_cnt;
    logic          col_wrap;

    assign accept  = valid_i && (state_q == RUN);
    // Columns 0 and 1 of each band only prime the buffer; no window yet.
    assign win_hit = accept && (col_cnt >= COL_FIRST_WIN);

    mod_counter #(
        .MOD (COLS),
        .W   (CW)
    ) u_col_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (cnt_clr),
        .en    (accept),
        .count (col_cnt),
        .wrap  (col_wrap)
    );

    // The band counter wraps exactly on the final beat of the frame.
    mod_counter #(
        .MOD (ROWS - 2),
        .W   (BW)
    ) u_band_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (cnt_clr),
        .en    (col_wrap),
        .count (band_cnt),
        .wrap  (last_beat)
    );

    always_comb begin
        state_d   = state_q;
        overrun_d = overrun_q;
        cnt_clr   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d   = RUN;
                    cnt_clr   = 1'b1;
                    overrun_d = 1'b0;
                end else if (valid_i) begin
                    overrun_d = 1'b1;
                end
            end
            RUN: begin
                if (last_beat) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
                if (valid_i) begin
                    overrun_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        edge_d             = '0;
        edge_d[EDGE_TOP]   = (band_cnt == '0);
        edge_d[EDGE_BOT]   = (band_cnt == BAND_LAST);
        edge_d[EDGE_LEFT]  = (col_cnt == COL_FIRST_WIN);
        edge_d[EDGE_RIGHT] = (col_cnt == COL_LAST);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            overrun_q   <= 1'b0;
            win_valid_q <= 1'b0;
            win_col_q   <= '0;
            win_row_q   <= '0;
            edge_q      <= '0;
        end else begin
            state_q     <= state_d;
            overrun_q   <= overrun_d;
            win_valid_q <= win_hit;
            // Tags hold between windows so downstream can read them at leisure.
            if (win_hit) begin
                win_col_q <= col_cnt - CW'(1);
                win_row_q <= RW'(band_cnt) + RW'(1);
                edge_q    <= edge_d;
            end
        end
    end

    assign shift_en_o   = accept;
    assign win_valid_o  = win_valid_q;
    assign win_col_o    = win_col_q;
    assign win_row_o    = win_row_q;
    assign edge_o       = edge_q;
    assign busy_o       = (state_q == RUN);
    assign frame_done_o = (state_q == DONE);
    assign overrun_o    = overrun_q;

endmodule
